seq_mag_comparator: RTL

//  Parametrised, digit-serial magnitude comparator: successor of the fixed 3-bit

---
 rtl/seq_mag_comparator_if.sv | 25 ++
 rtl/seq_mag_comparator.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_mag_comparator_if.sv
// Handshake and operand bundle for the digit-serial magnitude comparator.
// The master drives the request and operands; the slave returns status and result.
interface seq_mag_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gr;
  logic             le;
  logic             eq;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, gr, le, eq
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, gr, le, eq
  );
endinterface

// File: rtl/seq_mag_comparator.sv
// Digit-serial magnitude comparator. Operands are latched on an accepted start
// and scanned MSB-first, DIGIT bits per clock. Two's-complement compares are
// turned into unsigned ones by inverting each operand's sign bit at latch time.
// The first unequal digit decides the outcome; with EARLY_EXIT the scan stops
// there, otherwise it runs all digits for a fixed latency.
module seq_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_mag_comparator_if.slave  ifc
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  typedef enum logic {
    S_IDLE,
    S_CMP
  } state_t;

  // Running outcome of the scan: NONE means every digit so far was equal.
  typedef enum logic [1:0] {
    D_NONE,
    D_GR,
    D_LE
  } dec_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a, w_a_next;
  logic [WIDTH-1:0] r_b, w_b_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  dec_t             r_dec, w_dec_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_gr, w_gr_next;
  logic             r_le, w_le_next;
  logic             r_eq, w_eq_next;

  // The operand registers shift left every digit, so the digit under test is
  // always the top DIGIT bits; no variable indexing is needed.
  logic [DIGIT-1:0] w_dig_a;
  logic [DIGIT-1:0] w_dig_b;
  logic [WIDTH-1:0] w_sign_flip;
  dec_t             w_dec_now;
  logic             w_finish;

  assign w_dig_a     = r_a[WIDTH-1 -: DIGIT];
  assign w_dig_b     = r_b[WIDTH-1 -: DIGIT];
  assign w_sign_flip = WIDTH'(ifc.signed_mode) << (WIDTH - 1);

  // Keep an earlier decision; otherwise the current digit may decide.
  always_comb begin
    w_dec_now = r_dec;
    if (r_dec == D_NONE) begin
      if (w_dig_a > w_dig_b) begin
        w_dec_now = D_GR;
      end else if (w_dig_a < w_dig_b) begin
        w_dec_now = D_LE;
      end
    end
  end

  assign w_finish = ((EARLY_EXIT != 0) && (w_dec_now != D_NONE)) ||
                    (r_cnt == LAST_DIGIT);

  // Next-state and output logic for the IDLE/CMP sequencer.
  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_cnt_next   = r_cnt;
    w_dec_next   = r_dec;
    w_busy_next  = r_busy;
    w_done_next  = r_done;
    w_gr_next    = r_gr;
    w_le_next    = r_le;
    w_eq_next    = r_eq;

    case (r_state)
      S_IDLE: begin
        w_done_next = 1'b0;
        if (ifc.start) begin
          w_state_next = S_CMP;
          w_a_next     = ifc.a ^ w_sign_flip;
          w_b_next     = ifc.b ^ w_sign_flip;
          w_cnt_next   = '0;
          w_dec_next   = D_NONE;
          w_busy_next  = 1'b1;
          w_gr_next    = 1'b0;
          w_le_next    = 1'b0;
          w_eq_next    = 1'b0;
        end
      end
      S_CMP: begin
        w_a_next   = r_a << DIGIT;
        w_b_next   = r_b << DIGIT;
        w_dec_next = w_dec_now;
        if (w_finish) begin
          w_state_next = S_IDLE;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_gr_next    = (w_dec_now == D_GR);
          w_le_next    = (w_dec_now == D_LE);
          w_eq_next    = (w_dec_now == D_NONE);
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand, counter, decision and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_dec  <= D_NONE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_gr   <= 1'b0;
      r_le   <= 1'b0;
      r_eq   <= 1'b0;
    end else begin
      r_a    <= w_a_next;
      r_b    <= w_b_next;
      r_cnt  <= w_cnt_next;
      r_dec  <= w_dec_next;
      r_busy <= w_busy_next;
      r_done <= w_done_next;
      r_gr   <= w_gr_next;
      r_le   <= w_le_next;
      r_eq   <= w_eq_next;
    end
  end

  assign ifc.busy = r_busy;
  assign ifc.done = r_done;
  assign ifc.gr   = r_gr;
  assign ifc.le   = r_le;
  assign ifc.eq   = r_eq;

endmodule
